// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: controller state encoding,
// default operand width and the strobe bundle seen by the datapath top.
package mult_pkg;

  localparam int N_DEF = 4;
  localparam int CNT_W = $clog2(N_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } mult_state_t;

  // One registered strobe per field; bit order is fixed for the datapath.
  typedef struct packed {
    logic clrp;
    logic ldm;
    logic ldq;
    logic ldp;
    logic shp;
    logic shq;
    logic busy;
    logic done;
  } mult_ctrl_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and strobe bundle between the multiplier controller (master)
// and the requester/datapath side (slave).
interface mult_seq_ctrl_if;

  logic start;
  logic abort;
  logic q0;
  logic clrp;
  logic ldm;
  logic ldq;
  logic ldp;
  logic shp;
  logic shq;
  logic busy;
  logic done;

  modport master (
    input  start, abort, q0,
    output clrp, ldm, ldq, ldp, shp, shq, busy, done
  );

  modport slave (
    output start, abort, q0,
    input  clrp, ldm, ldq, ldp, shp, shq, busy, done
  );

endinterface

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier controller: synchronous clear,
// increment enable, terminal flag when the last iteration is reached.
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N)
) (
  input  logic clk,
  input  logic clr,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_cnt;

  // Count iterations; sync clear wins over increment.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_term = (r_cnt == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the sequential shift-and-add multiplier. All strobes are
// registered and derived from the next state, so each one is high for
// exactly the cycles the FSM occupies the matching state.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            clr,
  mult_seq_ctrl_if.master bus
);

  localparam int CW = (N == N_DEF) ? CNT_W : $clog2(N);

  mult_state_t r_state;
  mult_state_t w_next;
  mult_ctrl_t  r_ctrl;
  mult_ctrl_t  w_ctrl;
  logic        w_term;
  logic        w_cnt_clr;
  logic        w_cnt_inc;

  mult_iter_cnt #(
    .N  (N),
    .CW (CW)
  ) u_cnt (
    .clk    (clk),
    .clr    (clr),
    .i_clr  (w_cnt_clr),
    .i_inc  (w_cnt_inc),
    .o_term (w_term)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_LOAD;
      S_LOAD:  w_next = S_ADD;
      S_ADD:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_term ? S_FLUSH : S_ADD;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && bus.abort) w_next = S_IDLE;
  end

  // Counter restarts on entry to LOAD and advances on each SHIFT->ADD.
  assign w_cnt_clr = (w_next == S_LOAD);
  assign w_cnt_inc = (r_state == S_SHIFT) && (w_next == S_ADD);

  // Strobe decode from the next state; ldp takes q0 as it enters ADD.
  always_comb begin
    w_ctrl      = '0;
    w_ctrl.busy = (w_next != S_IDLE);
    case (w_next)
      S_CLEAR: w_ctrl.clrp = 1'b1;
      S_LOAD: begin
        w_ctrl.ldm = 1'b1;
        w_ctrl.ldq = 1'b1;
      end
      S_ADD:   w_ctrl.ldp = bus.q0;
      S_SHIFT: begin
        w_ctrl.shp = 1'b1;
        w_ctrl.shq = 1'b1;
      end
      S_DONE:  w_ctrl.done = 1'b1;
      default: ;
    endcase
  end

  // Output register keeps every strobe glitch-free.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_ctrl <= '0;
    else     r_ctrl <= w_ctrl;
  end

  assign bus.clrp = r_ctrl.clrp;
  assign bus.ldm  = r_ctrl.ldm;
  assign bus.ldq  = r_ctrl.ldq;
  assign bus.ldp  = r_ctrl.ldp;
  assign bus.shp  = r_ctrl.shp;
  assign bus.shq  = r_ctrl.shq;
  assign bus.busy = r_ctrl.busy;
  assign bus.done = r_ctrl.done;

endmodule
